caxi4dma_int_status_arb: RTL



---
 rtl/caxi4dma_int_status_arb_pkg.sv | 23 ++
 rtl/caxi4dma_int_status_arb_if.sv | 38 +++
 rtl/caxi4dma_int_status_arb_rr_arbiter.sv | 65 ++++++
 rtl/caxi4dma_int_status_arb.sv | 105 ++++++++++
 4 files changed

// File: rtl/caxi4dma_int_status_arb_pkg.sv
// caxi4dma_int_pkg: shared definitions for the interrupt status arbiter.
// Holds the status flag bit positions, the flag field width, the output
// stage state enum and a helper that classifies a flag word as an error.
package caxi4dma_int_pkg;

  localparam int FLAGS_W             = 5;
  localparam int FLG_OP_DONE         = 0;
  localparam int FLG_WR_ERR          = 1;
  localparam int FLG_RD_ERR          = 2;
  localparam int FLG_INV_DSCRPTR_ERR = 3;
  localparam int FLG_STR_DSCRPTR     = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Any of the three error flags marks a record as high class.
  function automatic logic is_err(input logic [FLAGS_W-1:0] f);
    return f[FLG_WR_ERR] | f[FLG_RD_ERR] | f[FLG_INV_DSCRPTR_ERR];
  endfunction

endpackage

// File: rtl/caxi4dma_int_status_arb_if.sv
// caxi4dma_int_status_arb_if: source-side request bus and registered output
// record bus of the interrupt status arbiter.
//   slave  : the arbiter (takes src_* and out_ready, drives src_ack and out_*)
//   master : the environment (drives src_* and out_ready)
// Signals: src_req/src_ack (per source), src_dnum/src_addr/src_flags (packed,
// source i at [i*W +: W]), out_valid/out_ready, out_src/out_dnum/out_addr/out_flags.
interface caxi4dma_int_status_arb_if
  import caxi4dma_int_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DNUM_W  = 2,
  parameter int ADDR_W  = 32
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]         src_req;
  logic [NUM_SRC-1:0]         src_ack;
  logic [NUM_SRC*DNUM_W-1:0]  src_dnum;
  logic [NUM_SRC*ADDR_W-1:0]  src_addr;
  logic [NUM_SRC*FLAGS_W-1:0] src_flags;
  logic                       out_valid;
  logic                       out_ready;
  logic [SRC_W-1:0]           out_src;
  logic [DNUM_W-1:0]          out_dnum;
  logic [ADDR_W-1:0]          out_addr;
  logic [FLAGS_W-1:0]         out_flags;

  modport slave (
    input  src_req, src_dnum, src_addr, src_flags, out_ready,
    output src_ack, out_valid, out_src, out_dnum, out_addr, out_flags
  );

  modport master (
    output src_req, src_dnum, src_addr, src_flags, out_ready,
    input  src_ack, out_valid, out_src, out_dnum, out_addr, out_flags
  );

endinterface

// File: rtl/caxi4dma_int_status_arb_rr_arbiter.sv
// caxi4dma_rr_arbiter: round-robin search over NUM_SRC requests.
// Picks the first requesting index at or after ptr_in, ascending with wrap.
// Ports: clock, reset; req (request vector), ptr_in (search start), enable;
// ptr_ld/ptr_ld_idx (final grant, advances the pointer); gnt (one-hot),
// gnt_idx, any_gnt; ptr (pointer value).
// With HAS_PTR=1 the instance holds the pointer register; otherwise it only
// searches and passes ptr_in through, so several classes can share one pointer.
module caxi4dma_rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter bit HAS_PTR = 1'b1,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr_in,
  input  logic               enable,
  input  logic               ptr_ld,
  input  logic [IDX_W-1:0]   ptr_ld_idx,
  output logic [NUM_SRC-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_gnt,
  output logic [IDX_W:0]     ptr_unused_w,
  output logic [IDX_W-1:0]   ptr
);

  logic [IDX_W:0] cand;
  logic           found;

  // ptr_in + k never exceeds 2*NUM_SRC-2, so one conditional subtract
  // implements the modulo for any NUM_SRC, power of two or not.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, ptr_in} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_SRC)) cand = cand - (IDX_W+1)'(NUM_SRC);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
    if (enable && found) gnt[gnt_idx] = 1'b1;
  end

  assign any_gnt      = enable & found;
  assign ptr_unused_w = cand;

  if (HAS_PTR) begin : g_ptr
    logic [IDX_W-1:0] ptr_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) ptr_q <= '0;
      else if (ptr_ld)
        ptr_q <= (ptr_ld_idx == IDX_W'(NUM_SRC-1)) ? '0 : ptr_ld_idx + 1'b1;
    end
    assign ptr = ptr_q;
  end else begin : g_no_ptr
    logic ptr_ld_unused;
    assign ptr_ld_unused = ^{clock, reset, ptr_ld, ptr_ld_idx};
    assign ptr = ptr_in;
  end

endmodule

// File: rtl/caxi4dma_int_status_arb.sv
// caxi4dma_int_status_arb: N-source interrupt status arbiter. Grants one
// completion/error record per cycle round-robin, acknowledges the source in
// the same cycle and captures the record into a registered valid/ready stage.
// Ports: clock, reset (async, active high); bus (caxi4dma_int_status_arb_if.slave).
// Macro CAXI4DMA_INT_ERR_PRIO_EN: when defined, records carrying wr_err, rd_err
// or inv_dscrptr_err are searched first; both classes share one pointer.
module caxi4dma_int_status_arb
  import caxi4dma_int_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DNUM_W  = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  caxi4dma_int_status_arb_if.slave    bus
);

  localparam int IDX_W = $clog2(NUM_SRC);

  out_state_e         state_q, state_d;
  logic               can_load, any_gnt, valid_c;
  logic [NUM_SRC-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx, ptr_q;

  // Reset also blocks grants so no source sees an ack it would lose.
  assign can_load = ~reset & ((state_q == ST_EMPTY) | bus.out_ready);

`ifdef CAXI4DMA_INT_ERR_PRIO_EN
  logic [NUM_SRC-1:0] hi_req, nm_req, hi_gnt, nm_gnt;
  logic [IDX_W-1:0]   hi_idx, nm_idx, ptr_nm_unused;
  logic [IDX_W:0]     cand_hi_unused, cand_nm_unused;
  logic               hi_any, nm_any;

  always_comb begin
    hi_req = '0;
    for (int i = 0; i < NUM_SRC; i++)
      hi_req[i] = bus.src_req[i] & is_err(bus.src_flags[i*FLAGS_W +: FLAGS_W]);
  end
  assign nm_req = bus.src_req & ~hi_req;

  caxi4dma_rr_arbiter #(.NUM_SRC(NUM_SRC), .HAS_PTR(1'b1)) u_arb_hi (
    .clock(clock), .reset(reset), .req(hi_req), .ptr_in(ptr_q),
    .enable(can_load), .ptr_ld(any_gnt), .ptr_ld_idx(gnt_idx),
    .gnt(hi_gnt), .gnt_idx(hi_idx), .any_gnt(hi_any),
    .ptr_unused_w(cand_hi_unused), .ptr(ptr_q)
  );

  caxi4dma_rr_arbiter #(.NUM_SRC(NUM_SRC), .HAS_PTR(1'b0)) u_arb_nm (
    .clock(clock), .reset(reset), .req(nm_req), .ptr_in(ptr_q),
    .enable(can_load & ~hi_any), .ptr_ld(any_gnt), .ptr_ld_idx(gnt_idx),
    .gnt(nm_gnt), .gnt_idx(nm_idx), .any_gnt(nm_any),
    .ptr_unused_w(cand_nm_unused), .ptr(ptr_nm_unused)
  );

  assign gnt     = hi_gnt | nm_gnt;
  assign gnt_idx = hi_any ? hi_idx : nm_idx;
  assign any_gnt = hi_any | nm_any;
`else
  logic [IDX_W:0] cand_unused;

  caxi4dma_rr_arbiter #(.NUM_SRC(NUM_SRC), .HAS_PTR(1'b1)) u_arb (
    .clock(clock), .reset(reset), .req(bus.src_req), .ptr_in(ptr_q),
    .enable(can_load), .ptr_ld(any_gnt), .ptr_ld_idx(gnt_idx),
    .gnt(gnt), .gnt_idx(gnt_idx), .any_gnt(any_gnt),
    .ptr_unused_w(cand_unused), .ptr(ptr_q)
  );
`endif

  assign bus.src_ack = gnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (any_gnt) state_d = ST_FULL;
      ST_FULL:  if (bus.out_ready && !any_gnt) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    valid_c = (state_q == ST_FULL);
  end
  assign bus.out_valid = valid_c;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_src   <= '0;
      bus.out_dnum  <= '0;
      bus.out_addr  <= '0;
      bus.out_flags <= '0;
    end else if (any_gnt) begin
      bus.out_src   <= gnt_idx;
      bus.out_dnum  <= bus.src_dnum[int'(gnt_idx)*DNUM_W +: DNUM_W];
      bus.out_addr  <= bus.src_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      bus.out_flags <= bus.src_flags[int'(gnt_idx)*FLAGS_W +: FLAGS_W];
    end
  end

endmodule
